// File: rtl/status_frame_rx.sv
// Status frame receiver: deserializes 4-bit frames, accepts a value after repeated identical frames.
// Optional alarm memory is enabled by defining ALARM_MEMORY_EN.
module status_frame_rx #(
  parameter int MATCH_COUNT  = 2,
  parameter int LINK_TIMEOUT = 64,
  parameter int BLINK_HALF   = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic STATUS_IN,
  input  logic STATUS_SEND_IN,
  input  logic MEM_CLR,
  output logic ARMED_OUT,
  output logic ALARM_OUT,
  output logic SENS1_OUT,
  output logic SENS2_OUT,
  output logic ALARM_BLINK,
  output logic FRAME_VALID,
  output logic FRAME_ERR,
  output logic LINK_OK,
  output logic ALARM_MEM_OUT
);

  localparam logic [2:0] MC  = 3'(MATCH_COUNT);
  localparam logic [7:0] LT  = 8'(LINK_TIMEOUT);
  localparam logic [7:0] BH1 = 8'(BLINK_HALF - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK, FLUSH} state_t;

  state_t     state_q;
  logic [3:0] shift_q, cand_q, status_q, status_d;
  logic [2:0] idx_q, match_cnt_q, match_cnt_d;
  logic [7:0] link_cnt_q, link_cnt_d, blink_cnt_q;
  logic       link_ok_q, frame_valid_q, frame_err_q, blink_q;
  logic       frame_done, load, timeout;

  always_comb begin
    frame_done = (state_q == RECV) && (idx_q == 3'd4) && !STATUS_SEND_IN;
    if (shift_q == cand_q)
      match_cnt_d = (match_cnt_q >= MC) ? MC : match_cnt_q + 3'd1;
    else
      match_cnt_d = 3'd1;
    load       = frame_done && (match_cnt_d == MC);
    status_d   = load ? shift_q : status_q;
    link_cnt_d = frame_done ? 8'd0 : ((link_cnt_q == 8'hFF) ? 8'hFF : link_cnt_q + 8'd1);
    // Fires once on reaching the limit, not every cycle while saturated
    timeout    = (link_cnt_d == LT) && (link_cnt_q != LT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cand_q        <= '0;
      status_q      <= '0;
      idx_q         <= '0;
      match_cnt_q   <= '0;
      link_cnt_q    <= '0;
      link_ok_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      link_cnt_q    <= link_cnt_d;
      status_q      <= status_d;
      if (timeout) begin
        link_ok_q   <= 1'b0;
        match_cnt_q <= '0;
      end
      case (state_q)
        IDLE, CHECK: begin
          if (STATUS_SEND_IN) begin
            shift_q <= {STATUS_IN, shift_q[3:1]};
            idx_q   <= 3'd1;
            state_q <= RECV;
          end else begin
            state_q <= IDLE;
          end
        end
        RECV: begin
          if (STATUS_SEND_IN) begin
            if (idx_q == 3'd4) begin
              frame_err_q <= 1'b1;
              match_cnt_q <= '0;
              state_q     <= FLUSH;
            end else begin
              shift_q <= {STATUS_IN, shift_q[3:1]};
              idx_q   <= idx_q + 3'd1;
            end
          end else if (frame_done) begin
            frame_valid_q <= 1'b1;
            cand_q        <= shift_q;
            match_cnt_q   <= match_cnt_d;
            if (load) link_ok_q <= 1'b1;
            state_q       <= CHECK;
          end else begin
            frame_err_q <= 1'b1;
            match_cnt_q <= '0;
            state_q     <= IDLE;
          end
        end
        FLUSH: if (!STATUS_SEND_IN) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Blink holds low on the rising cycle so the first high phase starts one cycle later
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (!status_d[1]) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (status_q[1]) begin
      if (blink_cnt_q == 8'd0) blink_q <= ~blink_q;
      blink_cnt_q <= (blink_cnt_q == BH1) ? 8'd0 : blink_cnt_q + 8'd1;
    end
  end

`ifdef ALARM_MEMORY_EN
  logic mem_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          mem_q <= 1'b0;
    else if (load && shift_q[1])      mem_q <= 1'b1;
    else if (MEM_CLR && !status_q[1]) mem_q <= 1'b0;
  end
  assign ALARM_MEM_OUT = mem_q;
`else
  logic unused_mem_clr;
  assign unused_mem_clr = MEM_CLR;
  assign ALARM_MEM_OUT  = 1'b0;
`endif

  assign ARMED_OUT   = status_q[0];
  assign ALARM_OUT   = status_q[1];
  assign SENS1_OUT   = status_q[2];
  assign SENS2_OUT   = status_q[3];
  assign ALARM_BLINK = blink_q;
  assign FRAME_VALID = frame_valid_q;
  assign FRAME_ERR   = frame_err_q;
  assign LINK_OK     = link_ok_q;

endmodule

// File: tb/tb_status_frame_rx.sv
// Directed bench for status_frame_rx; memory checks follow ALARM_MEMORY_EN.
module tb_status_frame_rx;
  logic CLK = 1'b0;
  logic RST, STATUS_IN, STATUS_SEND_IN, MEM_CLR;
  logic ARMED_OUT, ALARM_OUT, SENS1_OUT, SENS2_OUT, ALARM_BLINK;
  logic FRAME_VALID, FRAME_ERR, LINK_OK, ALARM_MEM_OUT;
  logic [3:0] st;
  int n_pass = 0;
  int n_chk  = 0;

`ifdef ALARM_MEMORY_EN
  localparam logic MEM_EN = 1'b1;
`else
  localparam logic MEM_EN = 1'b0;
`endif

  status_frame_rx dut (
    .CLK(CLK), .RST(RST), .STATUS_IN(STATUS_IN), .STATUS_SEND_IN(STATUS_SEND_IN),
    .MEM_CLR(MEM_CLR), .ARMED_OUT(ARMED_OUT), .ALARM_OUT(ALARM_OUT),
    .SENS1_OUT(SENS1_OUT), .SENS2_OUT(SENS2_OUT), .ALARM_BLINK(ALARM_BLINK),
    .FRAME_VALID(FRAME_VALID), .FRAME_ERR(FRAME_ERR), .LINK_OK(LINK_OK),
    .ALARM_MEM_OUT(ALARM_MEM_OUT)
  );

  always #5 CLK = ~CLK;
  assign st = {SENS2_OUT, SENS1_OUT, ALARM_OUT, ARMED_OUT};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic drive(input logic send, input logic data);
    STATUS_SEND_IN = send;
    STATUS_IN      = data;
  endtask

  task automatic cyc(input logic send, input logic data);
    tick();
    drive(send, data);
  endtask

  // Four data bits LSB first, then SEND low; the next tick lands after the CHECK edge
  task automatic send_frame(input logic [3:0] f);
    for (int i = 0; i < 4; i++) cyc(1'b1, f[i]);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; MEM_CLR = 1'b0;
    drive(1'b0, 1'b0);
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rst_status", st, 4'b0000);
    chk("rst_link", {3'b0, LINK_OK}, 4'h0);
    chk("rst_pulses", {2'b0, FRAME_VALID, FRAME_ERR}, 4'h0);
    chk("rst_blink_mem", {2'b0, ALARM_BLINK, ALARM_MEM_OUT}, 4'h0);

    // Two 0001 frames
    send_frame(4'b0001); tick();
    chk("f1_valid", {3'b0, FRAME_VALID}, 4'h1);
    chk("f1_no_update", st, 4'b0000);
    tick(); tick(); tick();
    send_frame(4'b0001); tick();
    chk("f2_valid", {3'b0, FRAME_VALID}, 4'h1);
    chk("f2_status", st, 4'b0001);
    chk("f2_link", {3'b0, LINK_OK}, 4'h1);
    tick();
    chk("f2_valid_pulse", {3'b0, FRAME_VALID}, 4'h0);

    // 0011 then 0111 twice, then blink phases
    send_frame(4'b0011); tick();
    chk("f3_hold", st, 4'b0001);
    send_frame(4'b0111); tick();
    chk("f4_hold", st, 4'b0001);
    send_frame(4'b0111); tick();
    chk("f5_status", st, 4'b0111);
    chk("blink_rise_cycle", {3'b0, ALARM_BLINK}, 4'h0);
    tick();
    chk("blink_first_high", {3'b0, ALARM_BLINK}, 4'h1);
    repeat (7) tick();
    chk("blink_high_end", {3'b0, ALARM_BLINK}, 4'h1);
    tick();
    chk("blink_first_low", {3'b0, ALARM_BLINK}, 4'h0);
    repeat (7) tick();
    chk("blink_low_end", {3'b0, ALARM_BLINK}, 4'h0);
    tick();
    chk("blink_second_high", {3'b0, ALARM_BLINK}, 4'h1);

    // Short frame
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); tick();
    chk("short_err", {2'b0, FRAME_VALID, FRAME_ERR}, 4'b0001);
    chk("short_hold", st, 4'b0111);
    tick();
    chk("short_err_pulse", {3'b0, FRAME_ERR}, 4'h0);
    send_frame(4'b1001); tick();
    chk("f6_hold", st, 4'b0111);
    send_frame(4'b1001); tick();
    chk("f7_status", st, 4'b1001);
    chk("f7_blink_off", {3'b0, ALARM_BLINK}, 4'h0);

    // Long frame (6 cycles of SEND)
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    tick();
    chk("long_err", {2'b0, FRAME_VALID, FRAME_ERR}, 4'b0001);
    drive(1'b1, 1'b1); tick();
    chk("long_flush", {2'b0, FRAME_VALID, FRAME_ERR}, 4'b0000);
    drive(1'b0, 1'b0); tick();
    chk("long_idle", {2'b0, FRAME_VALID, FRAME_ERR}, 4'b0000);
    send_frame(4'b1001); tick();
    chk("after_long_valid", {2'b0, FRAME_VALID, FRAME_ERR}, 4'b0010);

    // Link timeout
    send_frame(4'b0001); tick();
    send_frame(4'b0001); tick();
    chk("to_status", st, 4'b0001);
    repeat (63) tick();
    chk("to_link_63", {3'b0, LINK_OK}, 4'h1);
    tick();
    chk("to_link_64", {3'b0, LINK_OK}, 4'h0);
    chk("to_hold", st, 4'b0001);
    send_frame(4'b0001); tick();
    chk("to_first_frame", {3'b0, LINK_OK}, 4'h0);
    send_frame(4'b0001); tick();
    chk("to_recovered", {3'b0, LINK_OK}, 4'h1);

    // Alarm memory
    send_frame(4'b0011); tick();
    send_frame(4'b0011); tick();
    chk("mem_alarm", {2'b0, ALARM_OUT, ALARM_MEM_OUT}, {2'b0, 1'b1, MEM_EN});
    MEM_CLR = 1'b1; tick(); MEM_CLR = 1'b0; tick();
    chk("mem_clr_blocked", {3'b0, ALARM_MEM_OUT}, {3'b0, MEM_EN});
    send_frame(4'b0000); tick();
    send_frame(4'b0000); tick();
    chk("mem_held", {2'b0, ALARM_OUT, ALARM_MEM_OUT}, {2'b0, 1'b0, MEM_EN});
    MEM_CLR = 1'b1; tick(); MEM_CLR = 1'b0;
    chk("mem_cleared", {3'b0, ALARM_MEM_OUT}, 4'h0);

    // Back-to-back frames
    send_frame(4'b0101);
    send_frame(4'b0101); tick();
    chk("b2b_status", st, 4'b0101);
    chk("b2b_valid", {3'b0, FRAME_VALID}, 4'h1);

    // Reset mid-frame
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); tick();
    RST = 1'b1; #1;
    chk("midrst_status", st, 4'b0000);
    chk("midrst_link_err", {2'b0, LINK_OK, FRAME_ERR}, 4'h0);
    drive(1'b0, 1'b0); tick();
    RST = 1'b0; tick();
    chk("midrst_no_err", {2'b0, FRAME_VALID, FRAME_ERR}, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
